udma_apb_master_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one APB master port among `N_REQ` configuration requesters, such as testbench agents, a boot loader and a debug bridge.
- Drives the uDMA core/peripheral register space.
- Runs APB SETUP/ACCESS phases per transfer and waits on `pready_i`.
- Returns read data and error status to the granted requester.
- Optionally performs atomic read-modify-write sequences, for example clock-gate set/clear, without releasing the bus between the read and the write.

---
 rtl/udma_apb_master_arb.sv | 208 ++++++++++++++++++++
 tb/tb_udma_apb_master_arb.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udma_apb_master_arb.sv
// udma_apb_master_arb
// Round-robin arbiter that shares one APB master port among N_REQ
// configuration requesters. Each granted request runs one APB transfer,
// or a locked read-modify-write when the optional RMW path is built in.
// Optional feature macro: UDMA_APB_ARB_RMW_EN (adds WSETUP/WACCESS and the
// set/clear mask merge). When it is undefined, req_rmw_i and req_clr_i are
// ignored and every request runs as a plain transfer.
module udma_apb_master_arb #(
    parameter int N_REQ      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [N_REQ-1:0]            req_valid_i,
    output logic [N_REQ-1:0]            req_ready_o,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata_i,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_clr_i,
    input  logic [N_REQ-1:0]            req_write_i,
    input  logic [N_REQ-1:0]            req_rmw_i,
    output logic [N_REQ-1:0]            rsp_valid_o,
    output logic [DATA_WIDTH-1:0]       rsp_rdata_o,
    output logic                        rsp_err_o,
    output logic [ADDR_WIDTH-1:0]       paddr_o,
    output logic [DATA_WIDTH-1:0]       pwdata_o,
    output logic                        pwrite_o,
    output logic                        psel_o,
    output logic                        penable_o,
    input  logic [DATA_WIDTH-1:0]       prdata_i,
    input  logic                        pready_i,
    input  logic                        pslverr_i
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        ACCESS  = 3'd2,
        WSETUP  = 3'd3,
        WACCESS = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [IDX_W-1:0]        rr_ptr;
    logic [IDX_W-1:0]        gnt;
    logic [IDX_W-1:0]        gnt_idx;
    logic                    gnt_found;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    write_q;
    logic                    err_q;
`ifdef UDMA_APB_ARB_RMW_EN
    logic [DATA_WIDTH-1:0]   clr_q;
    logic                    rmw_q;
`else
    // RMW inputs have no consumer in this build.
    logic                    unused_rmw;
    assign unused_rmw = ^{req_rmw_i, req_clr_i};
`endif

    // Pick the first valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        int k;
        k         = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            k = int'(rr_ptr) + i;
            if (k >= N_REQ) k = k - N_REQ;
            if (!gnt_found && req_valid_i[k]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDX_W'(k);
            end
        end
    end

    // State register; reset aborts any transfer in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state logic for the APB phase sequence.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (gnt_found) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS: begin
                if (pready_i) begin
`ifdef UDMA_APB_ARB_RMW_EN
                    if (rmw_q && !pslverr_i) state_next = WSETUP;
                    else                     state_next = RESP;
`else
                    state_next = RESP;
`endif
                end
            end
`ifdef UDMA_APB_ARB_RMW_EN
            WSETUP:  state_next = WACCESS;
            WACCESS: if (pready_i) state_next = RESP;
`endif
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: APB lines idle at zero outside bus phases.
    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        rsp_rdata_o = '0;
        rsp_err_o   = 1'b0;
        paddr_o     = '0;
        pwdata_o    = '0;
        pwrite_o    = 1'b0;
        psel_o      = 1'b0;
        penable_o   = 1'b0;
        case (state)
            IDLE: begin
                // Gated by reset so the grant stays low while held in reset.
                if (gnt_found && rst_ni) req_ready_o[gnt_idx] = 1'b1;
            end
            SETUP, ACCESS: begin
                psel_o    = 1'b1;
                penable_o = (state == ACCESS);
                paddr_o   = addr_q;
                pwdata_o  = wdata_q;
                pwrite_o  = write_q;
            end
            WSETUP, WACCESS: begin
                psel_o    = 1'b1;
                penable_o = (state == WACCESS);
                paddr_o   = addr_q;
                pwdata_o  = wdata_q;
                pwrite_o  = 1'b1;
            end
            RESP: begin
                rsp_valid_o[gnt] = 1'b1;
                rsp_rdata_o      = rdata_q;
                rsp_err_o        = err_q;
            end
            default: ;
        endcase
    end

    // Request latch, round-robin pointer and response capture.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr  <= '0;
            gnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef UDMA_APB_ARB_RMW_EN
            clr_q   <= '0;
            rmw_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        gnt     <= gnt_idx;
                        rr_ptr  <= (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
                        addr_q  <= req_addr_i[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        wdata_q <= req_wdata_i[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
                        rdata_q <= '0;
                        err_q   <= 1'b0;
`ifdef UDMA_APB_ARB_RMW_EN
                        clr_q   <= req_clr_i[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
                        rmw_q   <= req_rmw_i[gnt_idx];
                        // The first phase of an RMW is always a read.
                        write_q <= req_write_i[gnt_idx] & ~req_rmw_i[gnt_idx];
`else
                        write_q <= req_write_i[gnt_idx];
`endif
                    end
                end
                ACCESS: begin
                    if (pready_i) begin
                        // Plain writes report zero read data.
                        if (!write_q) rdata_q <= prdata_i;
                        err_q <= pslverr_i;
`ifdef UDMA_APB_ARB_RMW_EN
                        // Merge masks into the write-back value in place.
                        if (rmw_q && !pslverr_i)
                            wdata_q <= (prdata_i & ~clr_q) | wdata_q;
`endif
                    end
                end
`ifdef UDMA_APB_ARB_RMW_EN
                WACCESS: begin
                    if (pready_i) err_q <= err_q | pslverr_i;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_udma_apb_master_arb.sv
// Directed self-checking bench for udma_apb_master_arb (N_REQ=4, 32-bit).
// A small APB slave model answers after n_wait extra ACCESS cycles with
// slv_rdata/slv_err. RMW expectations follow UDMA_APB_ARB_RMW_EN.
module tb_udma_apb_master_arb;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N*DW-1:0]   req_clr;
    logic [N-1:0]      req_write;
    logic [N-1:0]      req_rmw;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic [AW-1:0]     paddr;
    logic [DW-1:0]     pwdata;
    logic              pwrite;
    logic              psel;
    logic              penable;
    logic [DW-1:0]     prdata;
    logic              pready;
    logic              pslverr;

    int                n_wait;
    int                acc_cnt;
    logic [DW-1:0]     slv_rdata;
    logic              slv_err;
    int                errors = 0;
    int                checks = 0;

    udma_apb_master_arb #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_clr_i(req_clr),
        .req_write_i(req_write), .req_rmw_i(req_rmw),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .paddr_o(paddr), .pwdata_o(pwdata), .pwrite_o(pwrite),
        .psel_o(psel), .penable_o(penable),
        .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
    );

    always #5 clk = ~clk;

    // APB slave model: ready after n_wait stalled ACCESS cycles.
    always @(posedge clk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
    end
    assign pready  = psel && penable && (acc_cnt >= n_wait);
    assign prdata  = slv_rdata;
    assign pslverr = slv_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_reqs();
        req_valid = '0; req_addr = '0; req_wdata = '0; req_clr = '0;
        req_write = '0; req_rmw = '0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_psel"},    64'(psel), 0);
        chk({tag, "_penable"}, 64'(penable), 0);
        chk({tag, "_pwrite"},  64'(pwrite), 0);
        chk({tag, "_paddr"},   64'(paddr), 0);
        chk({tag, "_pwdata"},  64'(pwdata), 0);
        chk({tag, "_ready"},   64'(req_ready), 0);
        chk({tag, "_rspv"},    64'(rsp_valid), 0);
        chk({tag, "_rdata"},   64'(rsp_rdata), 0);
        chk({tag, "_err"},     64'(rsp_err), 0);
    endtask

    // Issue one request on index idx and observe the whole transfer.
    task automatic do_xfer(input int idx, input logic wr, input logic rmw,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input logic [DW-1:0] clr,
                           output logic [N-1:0] gvec, output int lat,
                           output int pen_cnt, output int wr_cyc,
                           output logic [DW-1:0] last_wd, output logic [N-1:0] rvec,
                           output logic [DW-1:0] rdata, output logic err,
                           output logic [AW-1:0] addr0);
        bit done;
        gvec = '0; lat = 0; pen_cnt = 0; wr_cyc = 0; last_wd = '0;
        rvec = '0; rdata = '0; err = 1'b0; addr0 = '0;
        step();
        clear_reqs();
        req_valid[idx]             = 1'b1;
        req_write[idx]             = wr;
        req_rmw[idx]               = rmw;
        req_addr[idx*AW +: AW]     = addr;
        req_wdata[idx*DW +: DW]    = wd;
        req_clr[idx*DW +: DW]      = clr;
        #1;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (req_ready != 0) begin gvec = req_ready; done = 1'b1; end
            else begin step(); #1; end
        end
        if (!done) begin chk("grant_timeout", 0, 1); clear_reqs(); return; end
        step();
        clear_reqs();
        #1;
        done = 1'b0;
        for (int c = 1; c < 40 && !done; c++) begin
            if (psel && !penable && lat == 0) addr0 = paddr;
            if (psel && penable) pen_cnt++;
            if (psel && pwrite) begin wr_cyc++; last_wd = pwdata; end
            if (rsp_valid != 0) begin
                lat = c; rvec = rsp_valid; rdata = rsp_rdata; err = rsp_err; done = 1'b1;
            end else begin
                step(); #1;
            end
        end
        if (!done) chk("resp_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0]  gv, rv;
        logic [DW-1:0] lw, rd;
        logic [AW-1:0] a0;
        logic          er;
        int            lat, pc, wc;
        logic [N-1:0]  grants [5];
        int            gcyc [5];
        int            ng, overlap, cyc, stray;

        clear_reqs();
        n_wait = 0; slv_rdata = '0; slv_err = 1'b0;
        rst_n = 1'b0;
        req_valid = 4'b1111;

        // Reset state: everything low, grant suppressed during reset.
        step(); step(); #1;
        check_all_zero("reset");
        step();
        clear_reqs();
        rst_n = 1'b1;

        // Single write, checked cycle by cycle.
        slv_rdata = 32'h1234_5678;
        step();
        req_valid[0] = 1'b1; req_write[0] = 1'b1;
        req_addr[0 +: AW] = 32'h90; req_wdata[0 +: DW] = 32'h1C00_0000;
        #1;
        chk("wr_T_ready", 64'(req_ready), 64'h1);
        chk("wr_T_psel", 64'(psel), 0);
        step(); clear_reqs(); #1;
        chk("wr_T1_psel", 64'(psel), 1);
        chk("wr_T1_penable", 64'(penable), 0);
        chk("wr_T1_paddr", 64'(paddr), 64'h90);
        chk("wr_T1_pwrite", 64'(pwrite), 1);
        chk("wr_T1_pwdata", 64'(pwdata), 64'h1C00_0000);
        step(); #1;
        chk("wr_T2_penable", 64'(penable), 1);
        chk("wr_T2_rspv", 64'(rsp_valid), 0);
        step(); #1;
        chk("wr_T3_rspv", 64'(rsp_valid), 64'h1);
        chk("wr_T3_rdata", 64'(rsp_rdata), 0);
        chk("wr_T3_err", 64'(rsp_err), 0);
        chk("wr_T3_psel", 64'(psel), 0);
        chk("wr_T3_penable", 64'(penable), 0);
        step(); #1;
        chk("wr_T4_rspv", 64'(rsp_valid), 0);

        // Read with three wait states on requester 1.
        n_wait = 3; slv_rdata = 32'hDEAD_BEEF;
        do_xfer(1, 1'b0, 1'b0, 32'hA4, 32'h0, 32'h0, gv, lat, pc, wc, lw, rv, rd, er, a0);
        chk("ws_grant", 64'(gv), 64'h2);
        chk("ws_paddr", 64'(a0), 64'hA4);
        chk("ws_penable_cycles", 64'(pc), 4);
        chk("ws_latency", 64'(lat), 6);
        chk("ws_rspv", 64'(rv), 64'h2);
        chk("ws_rdata", 64'(rd), 64'hDEAD_BEEF);
        chk("ws_err", 64'(er), 0);
        n_wait = 0;

        // RMW: read 0x5, clear 0x1, set 0x2 on requester 2.
        slv_rdata = 32'h5;
        do_xfer(2, 1'b0, 1'b1, 32'h0, 32'h2, 32'h1, gv, lat, pc, wc, lw, rv, rd, er, a0);
        chk("rmw_grant", 64'(gv), 64'h4);
        chk("rmw_rspv", 64'(rv), 64'h4);
        chk("rmw_rdata", 64'(rd), 64'h5);
        chk("rmw_err", 64'(er), 0);
`ifdef UDMA_APB_ARB_RMW_EN
        chk("rmw_latency", 64'(lat), 5);
        chk("rmw_penable_cycles", 64'(pc), 2);
        chk("rmw_write_cycles", 64'(wc), 2);
        chk("rmw_pwdata", 64'(lw), 64'h6);
`else
        chk("rmw_latency", 64'(lat), 3);
        chk("rmw_penable_cycles", 64'(pc), 1);
        chk("rmw_write_cycles", 64'(wc), 0);
`endif

        // RMW whose read errors: no write phase, error reported.
        slv_err = 1'b1;
        do_xfer(3, 1'b0, 1'b1, 32'h0, 32'h2, 32'h1, gv, lat, pc, wc, lw, rv, rd, er, a0);
        chk("rmwerr_grant", 64'(gv), 64'h8);
        chk("rmwerr_latency", 64'(lat), 3);
        chk("rmwerr_write_cycles", 64'(wc), 0);
        chk("rmwerr_rspv", 64'(rv), 64'h8);
        chk("rmwerr_err", 64'(er), 1);
        chk("rmwerr_rdata", 64'(rd), 64'h5);
        slv_err = 1'b0;

        // Round robin: pointer is back at 0; all four hold valid.
        step();
        clear_reqs();
        req_valid = 4'b1111;
        ng = 0; overlap = 0; cyc = 0;
        for (int c = 0; c < 60 && ng < 5; c++) begin
            #1;
            if (req_ready != 0) begin
                if (rsp_valid != 0) overlap++;
                grants[ng] = req_ready; gcyc[ng] = c; ng++;
            end
            if (ng < 5) step();
        end
        step();
        clear_reqs();
        for (int c = 0; c < 4; c++) step();
        chk("rr_count", 64'(ng), 5);
        chk("rr_resp_overlap", 64'(overlap), 0);
        if (ng == 5) begin
            chk("rr_g0", 64'(grants[0]), 64'h1);
            chk("rr_g1", 64'(grants[1]), 64'h2);
            chk("rr_g2", 64'(grants[2]), 64'h4);
            chk("rr_g3", 64'(grants[3]), 64'h8);
            chk("rr_g4", 64'(grants[4]), 64'h1);
            for (int i = 1; i < 5; i++) chk("rr_spacing", 64'(gcyc[i] - gcyc[i-1]), 4);
        end

        // Reset while the bus is stuck in ACCESS.
        n_wait = 1000;
        step();
        req_valid[1] = 1'b1; req_addr[AW +: AW] = 32'hA4;
        #1;
        chk("rst_grant", 64'(req_ready), 64'h2);
        step(); clear_reqs();
        step(); step(); #1;
        chk("rst_pre_penable", 64'(penable), 1);
        step();
        rst_n = 1'b0;
        step(); #1;
        check_all_zero("rstmid");
        step();
        n_wait = 0;
        rst_n = 1'b1;
        stray = 0;
        for (int c = 0; c < 6; c++) begin
            step(); #1;
            if (rsp_valid != 0 || psel) stray++;
        end
        chk("rst_no_stray_rsp", 64'(stray), 0);

        // After reset rr_ptr=0: req0 wins over req3.
        step();
        req_valid = 4'b1001;
        #1;
        chk("rst_rr_req0_first", 64'(req_ready), 64'h1);
        step();
        req_valid = 4'b1000;
        cyc = 0;
        #1;
        while (req_ready == 0 && cyc < 20) begin step(); #1; cyc++; end
        chk("rst_rr_req3_next", 64'(req_ready), 64'h8);
        step(); clear_reqs();
        for (int c = 0; c < 4; c++) step();

        // After another reset, req3 alone is granted immediately.
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        req_valid = 4'b1000;
        #1;
        chk("rst_req3_alone", 64'(req_ready), 64'h8);
        step(); clear_reqs();
        for (int c = 0; c < 4; c++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
